sap1_rom: RTL and testbench

- 16-word x 8-bit program/data memory for the SAP-1 computer.
- Drives the shared 8-bit W-bus only while its active-low enable CE_bar is asserted. Otherwise the output is high-impedance so other bus drivers can use the bus.
- Contents come from a default program image. A manual programming port can overwrite them, and reset restores the image.
- Sits between the memory address register (which supplies address) and the W-bus.

---
 rtl/sap1_rom.sv | 41 ++++
 tb/tb_sap1_rom.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sap1_rom.sv
// SAP-1 program/data memory: 16x8 register array preloaded from INIT, with a
// one-cycle registered read and a tri-state W-bus output gated by CE_bar.
module sap1_rom #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] INIT =
    128'h0000_0020_1814_1000_0000_F0E0_2C1B_1A09
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              CE_bar,
  output logic [DATA_W-1:0] data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Read and write share one edge; the nonblocking read returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT[DATA_W*i +: DATA_W];
      end
      rd_q <= '0;
    end else begin
      rd_q <= mem[address];
      if (prog_we) begin
        mem[prog_addr] <= prog_data;
      end
    end
  end

  assign data = CE_bar ? 'z : rd_q;

endmodule

// File: tb/tb_sap1_rom.sv
// Scoreboard bench for sap1_rom: a word-array model predicts each read, a
// negedge monitor compares the bus; the bus is pulled high so 'z reads 0xFF.
`timescale 1ns/1ps
module tb_sap1_rom;

  logic       tb_clk = 1'b0;
  logic       rst_n;
  logic [3:0] address;
  logic       CE_bar;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  wire  [7:0] data_bus;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  sap1_rom dut (
    .clk(tb_clk),
    .rst_n(rst_n),
    .address(address),
    .CE_bar(CE_bar),
    .data(data_bus),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 tb_clk = ~tb_clk;

  localparam logic [7:0] IMAGE [16] = '{
    8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
    8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00
  };

  logic [7:0] ref_mem [16];
  logic [7:0] last_rd;
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (ce_bar=%b t=%0t)", name, act, exp, CE_bar, $time);
  endtask

  function automatic logic [7:0] bus_expect(input logic [7:0] rd);
    return CE_bar ? 8'hFF : rd;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = IMAGE[i];
    last_rd = 8'h00;
  endtask

  // Present current inputs to one rising edge; model the edge and queue the read.
  task automatic step();
    logic [7:0] rd;
    @(posedge tb_clk);
    if (rst_n) begin
      rd = ref_mem[address];
      if (prog_we) ref_mem[prog_addr] = prog_data;
      last_rd = rd;
      exp_q.push_back(rd);
    end
    #1;
  endtask

  // Async reset between edges, after any queued read has been checked.
  task automatic pulse_reset();
    @(negedge tb_clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_bus", data_bus, bus_expect(8'h00));
    #1 rst_n = 1'b1;
  endtask

  always @(negedge tb_clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("read", data_bus, bus_expect(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; CE_bar = 1'b0; address = 4'h0;
    prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    model_reset();
    #1 check("reset_enabled", data_bus, 8'h00);
    CE_bar = 1'b1;
    #1 check("reset_disabled_z", data_bus, 8'hFF);
    CE_bar = 1'b0;
    #10 rst_n = 1'b1;

    // First read after reset, then a full sweep with wrap back to 0.
    step();
    for (int i = 1; i <= 17; i++) begin
      address = 4'(i);
      step();
    end

    // Enable toggling while the address keeps sweeping.
    CE_bar = 1'b1;
    fork
      begin
        #110 CE_bar = 1'b0;
        #1 check("enable_edge", data_bus, bus_expect(last_rd));
        for (int k = 0; k < 3; k++) begin
          #319 CE_bar = 1'b1;
          #1 check("disable_edge", data_bus, bus_expect(last_rd));
          #99 CE_bar = 1'b0;
          #1 check("enable_edge", data_bus, bus_expect(last_rd));
        end
      end
      begin
        for (int i = 0; i < 140; i++) begin
          address = address + 4'h1;
          step();
        end
      end
    join
    CE_bar = 1'b0;

    // Programming, then reset restores the image.
    prog_we = 1'b1; prog_addr = 4'h5; prog_data = 8'hA5; address = 4'h0;
    step();
    prog_we = 1'b0; address = 4'h5;
    step();
    pulse_reset();
    step();

    // Same-address read and write on one edge.
    address = 4'h3; prog_addr = 4'h3; prog_data = 8'h77; prog_we = 1'b1;
    step();
    prog_we = 1'b0;
    step();

    // Randomized traffic: enables, reads, writes, colliding addresses.
    for (int i = 0; i < 80; i++) begin
      address   = 4'($urandom_range(0, 15));
      CE_bar    = ($urandom_range(0, 3) == 0);
      prog_we   = ($urandom_range(0, 2) == 0);
      prog_addr = ($urandom_range(0, 3) == 0) ? address : 4'($urandom_range(0, 15));
      prog_data = 8'($urandom);
      step();
    end
    prog_we = 1'b0;

    // Async reset mid-sweep; programmed words must revert.
    CE_bar = 1'b0;
    for (int i = 0; i < 6; i++) begin
      address = 4'(i);
      step();
    end
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      step();
    end

    @(negedge tb_clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d reads left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
